// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: one combinational array multiplier shared by NREQ valid/ready requesters.
// Define MULT_SHARE_RR_EN for round-robin grants; otherwise the lowest requester index wins.

module n_bit_array_multiplier #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) p = p + ({{N{1'b0}}, a} << i);
    end
  end
endmodule

module mult_share_arbiter #(
  parameter  int N       = 8,
  parameter  int NREQ    = 4,
  parameter  int MUL_LAT = 1,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*N-1:0]    rsp_prod,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gid;
  logic            found;
  logic            accept;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    opa_p0, opb_p0;
  logic [2*N-1:0]  prod;

`ifdef MULT_SHARE_RR_EN
  logic [IDW-1:0] ptr;

  // Search begins one past the last granted requester.
  always_comb begin
    logic [IDW-1:0] idx;
    idx   = '0;
    gid   = '0;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gid   = idx;
      end
    end
    grant[gid] = found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= IDW'(NREQ - 1);
    else if (accept) ptr <= gid;
  end
`else
  always_comb begin
    gid   = '0;
    found = 1'b0;
    grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        gid   = IDW'(i);
      end
    end
    grant[gid] = found;
  end
`endif

  assign accept    = (state == IDLE) && found;
  assign req_ready = ((state == IDLE) && !rst) ? grant : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = CALC;
      CALC:    if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Stage p0: capture granted operands; they stay put outside CALC to keep the array quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_p0 <= '0;
      opb_p0 <= '0;
      rsp_id <= '0;
      cnt    <= '0;
    end else if (accept) begin
      opa_p0 <= req_a[int'(gid)*N +: N];
      opb_p0 <= req_b[int'(gid)*N +: N];
      rsp_id <= gid;
      cnt    <= CW'(MUL_LAT - 1);
    end else if ((state == CALC) && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  n_bit_array_multiplier #(.N(N)) u_mul (
    .a (opa_p0),
    .b (opb_p0),
    .p (prod)
  );

  // Stage p1: product sampled once the settle count expires, held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
    end else if ((state == CALC) && (cnt == '0)) begin
      rsp_valid <= 1'b1;
      rsp_prod  <= prod;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and randomised checks of mult_share_arbiter (MUL_LAT=1 main instance, MUL_LAT=3 side instance).

module tb_mult_share_arbiter;
  localparam int N    = 8;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [2*N-1:0]    rsp_prod;
  logic [1:0]        rsp_id;
  logic              busy;

  logic [NREQ-1:0]   req_valid3, req_ready3;
  logic [NREQ*N-1:0] req_a3, req_b3;
  logic              rsp_valid3, rsp_ready3;
  logic [2*N-1:0]    rsp_prod3;
  logic [1:0]        rsp_id3;
  logic              busy3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.N(N), .NREQ(NREQ), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_prod(rsp_prod), .rsp_id(rsp_id), .busy(busy)
  );

  mult_share_arbiter #(.N(N), .NREQ(NREQ), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_prod(rsp_prod3), .rsp_id(rsp_id3), .busy(busy3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic int winner(logic [NREQ-1:0] v, int p);
    int w;
    w = -1;
`ifdef MULT_SHARE_RR_EN
    for (int k = 1; k <= NREQ; k++)
      if (w < 0 && v[(p + k) % NREQ]) w = (p + k) % NREQ;
`else
    for (int i = NREQ - 1; i >= 0; i--)
      if (v[i]) w = i;
`endif
    return w;
  endfunction

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    tick(); tick();
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    tests++; if (rsp_prod !== 16'd0) begin fails++; $display("FAIL reset_rsp_prod: got %0d want 0", rsp_prod); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_single;
    bit ok;
    req_a[1*N +: N] = 8'd13; req_b[1*N +: N] = 8'd11; req_valid = 4'b0010;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL single_grant: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000)
      begin fails++; $display("FAIL single_calc: got valid=%b busy=%b ready=%b want 0 1 0000", rsp_valid, busy, req_ready); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_prod !== 16'd143 || rsp_id !== 2'd1)
      begin fails++; $display("FAIL single_rsp: got valid=%b prod=%0d id=%0d want 1 143 1", rsp_valid, rsp_prod, rsp_id); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin fails++; $display("FAIL single_done: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    wait_rsp(ok);
  endtask

  task automatic test_extremes;
    bit ok;
    req_a[0 +: N] = 8'd255; req_b[0 +: N] = 8'd255; req_valid = 4'b0001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL ext_grant0: got %b want 0001", req_ready); end
    tick(); req_valid = '0;
    wait_rsp(ok);
    tests++; if (!ok || rsp_prod !== 16'd65025 || rsp_id !== 2'd0)
      begin fails++; $display("FAIL ext_max: got valid=%b prod=%0d id=%0d want 1 65025 0", rsp_valid, rsp_prod, rsp_id); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    req_a[2*N +: N] = 8'd0; req_b[2*N +: N] = 8'd200; req_valid = 4'b0100;
    #1; tick(); req_valid = '0;
    wait_rsp(ok);
    tests++; if (!ok || rsp_prod !== 16'd0 || rsp_id !== 2'd2)
      begin fails++; $display("FAIL ext_zero: got valid=%b prod=%0d id=%0d want 1 0 2", rsp_valid, rsp_prod, rsp_id); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    req_a3[0 +: N] = 8'd5; req_b3[0 +: N] = 8'd6; req_valid3 = 4'b0001;
    #1;
    tests++; if (req_ready3 !== 4'b0001) begin fails++; $display("FAIL lat3_grant: got %b want 0001", req_ready3); end
    tick(); req_valid3 = '0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      tests++; if (rsp_valid3 !== (e == 3))
        begin fails++; $display("FAIL lat3_edge%0d: got valid=%b want %0d", e, rsp_valid3, (e == 3)); end
    end
    tests++; if (rsp_prod3 !== 16'd30 || rsp_id3 !== 2'd0)
      begin fails++; $display("FAIL lat3_rsp: got prod=%0d id=%0d want 30 0", rsp_prod3, rsp_id3); end
    rsp_ready3 = 1'b1; tick(); rsp_ready3 = 1'b0;
  endtask

  task automatic test_contention;
    int exp_order[5];
    int ngr, got, g;
`ifdef MULT_SHARE_RR_EN
    exp_order = '{0, 1, 2, 3, 0}; ngr = 5;
`else
    exp_order = '{0, 0, 0, 0, 0}; ngr = 3;
`endif
    got = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 8'(i + 1);
      req_b[i*N +: N] = 8'd10;
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c < 60 && got < ngr; c++) begin
      #1;
      if (rsp_valid) begin
        tests++; if (rsp_prod !== 16'((int'(rsp_id) + 1) * 10))
          begin fails++; $display("FAIL cont_prod: got %0d want %0d", rsp_prod, (int'(rsp_id) + 1) * 10); end
      end
      if (req_ready != 4'b0000) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        tests++; if ($countones(req_ready) != 1) begin fails++; $display("FAIL cont_onehot: got %b want one-hot", req_ready); end
        tests++; if (g != exp_order[got]) begin fails++; $display("FAIL cont_order%0d: got %0d want %0d", got, g, exp_order[got]); end
        got++;
      end
      tick();
    end
    tests++; if (got != ngr) begin fails++; $display("FAIL cont_count: got %0d grants want %0d", got, ngr); end
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    req_a[3*N +: N] = 8'd20; req_b[3*N +: N] = 8'd30; req_valid = 4'b1000;
    #1;
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0111;
    wait_rsp(ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_timeout: got valid=%b want 1", rsp_valid); end
    for (int c = 0; c < 5; c++) begin
      tests++; if (rsp_valid !== 1'b1 || rsp_prod !== 16'd600 || rsp_id !== 2'd3 || req_ready !== 4'b0000)
        begin fails++; $display("FAIL bp_hold%0d: got valid=%b prod=%0d id=%0d ready=%b want 1 600 3 0000", c, rsp_valid, rsp_prod, rsp_id, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready_indep: got %b want 0000", req_ready); end
    tick();
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0001)
      begin fails++; $display("FAIL bp_release: got valid=%b ready=%b want 0 0001", rsp_valid, req_ready); end
    req_valid = '0; rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    bit ok, rose;
    req_a[2*N +: N] = 8'd50; req_b[2*N +: N] = 8'd3; req_valid = 4'b0100;
    #1; tick(); req_valid = '0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b want 1", busy); end
    #2; rst = 1'b1; #1;
    tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_prod !== 16'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0000)
      begin fails++; $display("FAIL rmid_async: got busy=%b valid=%b prod=%0d id=%0d ready=%b want all zero", busy, rsp_valid, rsp_prod, rsp_id, req_ready); end
    tick(); tick();
    rst = 1'b0;
    rose = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid !== 1'b0) rose = 1'b1;
      tick();
    end
    tests++; if (rose) begin fails++; $display("FAIL rmid_no_rsp: got rsp_valid rise want none"); end
    req_a[3*N +: N] = 8'd7; req_b[3*N +: N] = 8'd9; req_valid = 4'b1000;
    #1; tick(); req_valid = '0;
    wait_rsp(ok);
    tests++; if (!ok || rsp_prod !== 16'd63 || rsp_id !== 2'd3)
      begin fails++; $display("FAIL rmid_next: got valid=%b prod=%0d id=%0d want 1 63 3", rsp_valid, rsp_prod, rsp_id); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_random;
    int issued[NREQ];
    int done[NREQ];
    bit pend;
    int pend_id, ops, rr_ptr, w, g;
    logic [15:0] pend_prod, ea, eb;
    logic [NREQ-1:0] exp_ready;
    pend = 1'b0; pend_id = 0; pend_prod = '0; ops = 0; rr_ptr = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin issued[i] = 0; done[i] = 0; end
    req_valid = '0; rsp_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 30000 && ops < 1000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a = 32'($urandom); req_b = 32'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      w = winner(req_valid, rr_ptr);
      exp_ready = (pend || w < 0) ? 4'b0000 : 4'(1 << w);
      tests++; if (req_ready !== exp_ready)
        begin fails++; $display("FAIL rnd_grant: got %b want %b", req_ready, exp_ready); end
      if ((req_ready & req_valid) != 4'b0000) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        ea = {8'd0, req_a[g*N +: N]}; eb = {8'd0, req_b[g*N +: N]};
        pend = 1'b1; pend_id = g; pend_prod = ea * eb; rr_ptr = g;
        issued[g]++; ops++;
      end
      if (rsp_valid && rsp_ready) begin
        tests++; if (!pend || rsp_id !== 2'(pend_id) || rsp_prod !== pend_prod)
          begin fails++; $display("FAIL rnd_rsp: got id=%0d prod=%0d want id=%0d prod=%0d pend=%b", rsp_id, rsp_prod, pend_id, pend_prod, pend); end
        done[rsp_id]++;
        pend = 1'b0;
      end
      tick();
    end
    tests++; if (ops != 1000) begin fails++; $display("FAIL rnd_ops: got %0d want 1000", ops); end
    req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid && rsp_ready) begin
        tests++; if (!pend || rsp_id !== 2'(pend_id) || rsp_prod !== pend_prod)
          begin fails++; $display("FAIL rnd_drain: got id=%0d prod=%0d want id=%0d prod=%0d", rsp_id, rsp_prod, pend_id, pend_prod); end
        done[rsp_id]++;
        pend = 1'b0;
      end
      tick();
    end
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      tests++; if (issued[i] != done[i])
        begin fails++; $display("FAIL rnd_count%0d: got %0d responses want %0d", i, done[i], issued[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0;
    test_reset();
    test_single();
    test_extremes();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
